// File: rtl/integer_datapath_if.sv
// Operand, control and result bundle for integer_datapath.
// master drives addresses, operands and controls; slave returns the ALU result, flags and store data.
interface integer_datapath_if;
   logic [4:0]  S_Addr;
   logic [4:0]  T_Addr;
   logic [4:0]  D_Addr;
   logic        D_En;
   logic [31:0] DT;
   logic        T_Sel;
   logic [4:0]  FS;
   logic        HILO_ld;
   logic [31:0] DY;
   logic [31:0] PC_in;
   logic [2:0]  Y_Sel;
   logic        C;
   logic        V;
   logic        N;
   logic        Z;
   logic [31:0] ALU_OUT;
   logic [31:0] D_OUT;

   modport master (
      output S_Addr, T_Addr, D_Addr, D_En, DT, T_Sel, FS, HILO_ld, DY, PC_in, Y_Sel,
      input  C, V, N, Z, ALU_OUT, D_OUT
   );

   modport slave (
      input  S_Addr, T_Addr, D_Addr, D_En, DT, T_Sel, FS, HILO_ld, DY, PC_in, Y_Sel,
      output C, V, N, Z, ALU_OUT, D_OUT
   );
endinterface

// File: rtl/integer_datapath.sv
// 32x32 register file, combinational ALU with flags, HI/LO pair and writeback mux.
// Define INTDP_WR_BYPASS_EN to forward writeback data to a read port addressing the register being written.
module integer_datapath (
   input  logic              clk,
   input  logic              reset,
   integer_datapath_if.slave bus
);
   localparam logic [4:0] FS_PASS_S = 5'h00;
   localparam logic [4:0] FS_PASS_T = 5'h01;
   localparam logic [4:0] FS_ADDU   = 5'h02;
   localparam logic [4:0] FS_ADD    = 5'h03;
   localparam logic [4:0] FS_SUB    = 5'h04;
   localparam logic [4:0] FS_SUBU   = 5'h05;
   localparam logic [4:0] FS_SLT    = 5'h06;
   localparam logic [4:0] FS_SLTU   = 5'h07;
   localparam logic [4:0] FS_AND    = 5'h08;
   localparam logic [4:0] FS_OR     = 5'h09;
   localparam logic [4:0] FS_XOR    = 5'h0A;
   localparam logic [4:0] FS_NOR    = 5'h0B;
   localparam logic [4:0] FS_SRL    = 5'h0C;
   localparam logic [4:0] FS_SRA    = 5'h0D;
   localparam logic [4:0] FS_SLL    = 5'h0E;
   localparam logic [4:0] FS_INC    = 5'h13;
   localparam logic [4:0] FS_DEC    = 5'h15;
   localparam logic [4:0] FS_ZEROS  = 5'h17;
   localparam logic [4:0] FS_ONES   = 5'h18;
   localparam logic [4:0] FS_MUL    = 5'h1E;
   localparam logic [4:0] FS_DIV    = 5'h1F;

   logic [31:0]        r_regs [0:31];
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;

   logic               w_wr_act;
   logic [31:0]        w_s;
   logic [31:0]        w_t_reg;
   logic [31:0]        w_t;
   logic [31:0]        w_wb;
   logic [31:0]        w_y_lo;
   logic [31:0]        w_y_hi;
   logic               w_c;
   logic               w_v;
   logic [32:0]        w_add;
   logic [32:0]        w_sub;
   logic [32:0]        w_inc;
   logic [32:0]        w_dec;
   logic signed [63:0] w_prod;
   logic [31:0]        w_quot;
   logic [31:0]        w_rem;

   assign w_wr_act = bus.D_En && (bus.D_Addr != 5'd0);

`ifdef INTDP_WR_BYPASS_EN
   // Forwarding ALU_OUT (Y_Sel=2) into a port that feeds the ALU closes a loop; drive that case with care.
   assign w_s     = (bus.S_Addr == 5'd0) ? 32'd0 :
                    (w_wr_act && (bus.S_Addr == bus.D_Addr)) ? w_wb : r_regs[bus.S_Addr];
   assign w_t_reg = (bus.T_Addr == 5'd0) ? 32'd0 :
                    (w_wr_act && (bus.T_Addr == bus.D_Addr)) ? w_wb : r_regs[bus.T_Addr];
`else
   assign w_s     = (bus.S_Addr == 5'd0) ? 32'd0 : r_regs[bus.S_Addr];
   assign w_t_reg = (bus.T_Addr == 5'd0) ? 32'd0 : r_regs[bus.T_Addr];
`endif

   assign w_t    = bus.T_Sel ? bus.DT : w_t_reg;
   assign w_add  = {1'b0, w_s} + {1'b0, w_t};
   assign w_sub  = {1'b0, w_s} - {1'b0, w_t};
   assign w_inc  = {1'b0, w_s} + 33'd1;
   assign w_dec  = {1'b0, w_s} - 33'd1;
   assign w_prod = $signed({{32{w_s[31]}}, w_s}) * $signed({{32{w_t[31]}}, w_t});

   // Divide-by-zero and the single overflowing quotient get fixed results instead of tool-defined ones.
   always_comb begin
      w_quot = 32'd0;
      w_rem  = 32'd0;
      if (w_t == 32'd0) begin
         w_quot = 32'hFFFF_FFFF;
         w_rem  = w_s;
      end else if ((w_s == 32'h8000_0000) && (w_t == 32'hFFFF_FFFF)) begin
         w_quot = 32'h8000_0000;
         w_rem  = 32'd0;
      end else begin
         w_quot = $unsigned($signed(w_s) / $signed(w_t));
         w_rem  = $unsigned($signed(w_s) % $signed(w_t));
      end
   end

   always_comb begin
      w_y_lo = 32'd0;
      w_y_hi = 32'd0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      case (bus.FS)
         FS_PASS_S: w_y_lo = w_s;
         FS_PASS_T: w_y_lo = w_t;
         FS_ADDU: begin
            w_y_lo = w_add[31:0];
            w_c    = w_add[32];
         end
         FS_ADD: begin
            w_y_lo = w_add[31:0];
            w_c    = w_add[32];
            w_v    = (w_s[31] == w_t[31]) && (w_add[31] != w_s[31]);
         end
         FS_SUB: begin
            w_y_lo = w_sub[31:0];
            w_c    = w_sub[32];
            w_v    = (w_s[31] != w_t[31]) && (w_sub[31] != w_s[31]);
         end
         FS_SUBU: begin
            w_y_lo = w_sub[31:0];
            w_c    = w_sub[32];
         end
         FS_SLT:   w_y_lo = {31'd0, ($signed(w_s) < $signed(w_t))};
         FS_SLTU:  w_y_lo = {31'd0, (w_s < w_t)};
         FS_AND:   w_y_lo = w_s & w_t;
         FS_OR:    w_y_lo = w_s | w_t;
         FS_XOR:   w_y_lo = w_s ^ w_t;
         FS_NOR:   w_y_lo = ~(w_s | w_t);
         FS_SRL: begin
            w_y_lo = {1'b0, w_t[31:1]};
            w_c    = w_t[0];
         end
         FS_SRA: begin
            w_y_lo = {w_t[31], w_t[31:1]};
            w_c    = w_t[0];
         end
         FS_SLL: begin
            w_y_lo = {w_t[30:0], 1'b0};
            w_c    = w_t[31];
         end
         FS_INC: begin
            w_y_lo = w_inc[31:0];
            w_c    = w_inc[32];
         end
         FS_DEC: begin
            w_y_lo = w_dec[31:0];
            w_c    = w_dec[32];
         end
         FS_ZEROS: w_y_lo = 32'd0;
         FS_ONES:  w_y_lo = 32'hFFFF_FFFF;
         FS_MUL: begin
            w_y_lo = w_prod[31:0];
            w_y_hi = w_prod[63:32];
         end
         FS_DIV: begin
            w_y_lo = w_quot;
            w_y_hi = w_rem;
         end
         default: w_y_lo = 32'd0;
      endcase
   end

   always_comb begin
      case (bus.Y_Sel)
         3'd0:    w_wb = bus.PC_in;
         3'd1:    w_wb = bus.DY;
         3'd2:    w_wb = w_y_lo;
         3'd3:    w_wb = r_lo;
         3'd4:    w_wb = r_hi;
         default: w_wb = 32'd0;
      endcase
   end

   // Y_hi is zero outside mul/div, so one 64-bit test covers both zero-flag definitions.
   assign bus.Z       = ({w_y_hi, w_y_lo} == 64'd0);
   assign bus.N       = w_y_lo[31];
   assign bus.C       = w_c;
   assign bus.V       = w_v;
   assign bus.ALU_OUT = w_y_lo;
   assign bus.D_OUT   = w_t_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else begin
         if (w_wr_act) r_regs[bus.D_Addr] <= w_wb;
         if (bus.HILO_ld) begin
            r_hi <= w_y_hi;
            r_lo <= w_y_lo;
         end
      end
   end
endmodule

// File: tb/tb_integer_datapath.sv
// Directed bench for integer_datapath: ALU vector table plus register-file, HI/LO and reset sequences.
// Honours INTDP_WR_BYPASS_EN when checking read-during-write.
module tb_integer_datapath;
   logic clk;
   logic reset;
   integer_datapath_if bus();

   integer_datapath dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  s_addr;
      logic [4:0]  t_addr;
      logic        t_sel;
      logic [31:0] dt;
      logic [4:0]  fs;
      logic [31:0] exp_y;
      logic [3:0]  exp_cvnz;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic [4:0] s, input logic [4:0] t, input logic ts,
                               input logic [31:0] dt, input logic [4:0] fs,
                               input logic [31:0] y, input logic [3:0] cvnz);
      vec_t v;
      v.s_addr = s; v.t_addr = t; v.t_sel = ts; v.dt = dt; v.fs = fs;
      v.exp_y = y; v.exp_cvnz = cvnz;
      return v;
   endfunction

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.S_Addr = 5'd0; bus.T_Addr = 5'd0; bus.D_Addr = 5'd0; bus.D_En = 1'b0;
      bus.DT = 32'd0; bus.T_Sel = 1'b0; bus.FS = 5'h00; bus.HILO_ld = 1'b0;
      bus.DY = 32'd0; bus.PC_in = 32'd0; bus.Y_Sel = 3'd0;
   endtask

   task automatic do_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] val);
      idle();
      bus.D_Addr = a; bus.DY = val; bus.Y_Sel = 3'd1; bus.D_En = 1'b1;
      do_clk();
      idle();
   endtask

   task automatic wb_reg(input logic [4:0] a, input logic [2:0] ysel);
      idle();
      bus.D_Addr = a; bus.Y_Sel = ysel; bus.D_En = 1'b1;
      do_clk();
      idle();
   endtask

   task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      idle();
      bus.S_Addr = a; bus.T_Addr = a; bus.FS = 5'h00;
      #1;
      check({name, "_s"}, {4'd0, bus.ALU_OUT}, {4'd0, exp});
      check({name, "_t"}, {4'd0, bus.D_OUT}, {4'd0, exp});
      @(negedge clk);
   endtask

   task automatic load_hilo(input logic [4:0] s, input logic [4:0] t, input logic ts,
                            input logic [31:0] dt, input logic [4:0] fs);
      idle();
      bus.S_Addr = s; bus.T_Addr = t; bus.T_Sel = ts; bus.DT = dt; bus.FS = fs;
      bus.HILO_ld = 1'b1;
      do_clk();
      idle();
   endtask

   initial begin
      //          S      T     Tsel DT            FS     Y              CVNZ
      vecs[0]  = mk(5'd3,  5'd4,  0, 32'h0,        5'h09, 32'h0F0F00F0, 4'b0000);
      vecs[1]  = mk(5'd2,  5'd5,  0, 32'h0,        5'h04, 32'h7FFFFFFF, 4'b0100);
      vecs[2]  = mk(5'd9,  5'd5,  0, 32'h0,        5'h02, 32'h00000000, 4'b1001);
      vecs[3]  = mk(5'd10, 5'd5,  0, 32'h0,        5'h03, 32'h80000000, 4'b0110);
      vecs[4]  = mk(5'd5,  5'd7,  0, 32'h0,        5'h05, 32'hFFFFFFFC, 4'b1010);
      vecs[5]  = mk(5'd9,  5'd5,  0, 32'h0,        5'h06, 32'h00000001, 4'b0000);
      vecs[6]  = mk(5'd9,  5'd5,  0, 32'h0,        5'h07, 32'h00000000, 4'b0001);
      vecs[7]  = mk(5'd9,  5'd3,  0, 32'h0,        5'h0A, 32'hF0F0FFFF, 4'b0010);
      vecs[8]  = mk(5'd3,  5'd4,  0, 32'h0,        5'h0B, 32'hF0F0FF0F, 4'b0010);
      vecs[9]  = mk(5'd0,  5'd5,  0, 32'h0,        5'h0C, 32'h00000000, 4'b1001);
      vecs[10] = mk(5'd0,  5'd2,  0, 32'h0,        5'h0D, 32'hC0000000, 4'b0010);
      vecs[11] = mk(5'd0,  5'd2,  0, 32'h0,        5'h0E, 32'h00000000, 4'b1001);
      vecs[12] = mk(5'd10, 5'd0,  0, 32'h0,        5'h13, 32'h80000000, 4'b0010);
      vecs[13] = mk(5'd7,  5'd0,  0, 32'h0,        5'h15, 32'h00000004, 4'b0000);
      vecs[14] = mk(5'd3,  5'd4,  0, 32'h0,        5'h17, 32'h00000000, 4'b0001);
      vecs[15] = mk(5'd3,  5'd4,  0, 32'h0,        5'h18, 32'hFFFFFFFF, 4'b0010);
      vecs[16] = mk(5'd3,  5'd4,  0, 32'h0,        5'h00, 32'h0F0F0000, 4'b0000);
      vecs[17] = mk(5'd3,  5'd4,  1, 32'h12345678, 5'h01, 32'h12345678, 4'b0000);
      vecs[18] = mk(5'd9,  5'd9,  0, 32'h0,        5'h10, 32'h00000000, 4'b0001);
      vecs[19] = mk(5'd3,  5'd9,  0, 32'h0,        5'h08, 32'h0F0F0000, 4'b0000);
      vecs[20] = mk(5'd8,  5'd0,  1, 32'hFFFFFFFB, 5'h1E, 32'hFFFFFFF1, 4'b0010);
      vecs[21] = mk(5'd6,  5'd7,  0, 32'h0,        5'h1F, 32'h00000003, 4'b0000);
      vecs[22] = mk(5'd6,  5'd0,  0, 32'h0,        5'h1F, 32'hFFFFFFFF, 4'b0010);
      vecs[23] = mk(5'd2,  5'd0,  1, 32'h00000002, 5'h1E, 32'h00000000, 4'b0000);
      vecs[24] = mk(5'd0,  5'd3,  0, 32'h0,        5'h1E, 32'h00000000, 4'b0001);
      vecs[25] = mk(5'd11, 5'd0,  1, 32'h00000002, 5'h1F, 32'hFFFFFFFD, 4'b0010);
      vecs[26] = mk(5'd10, 5'd5,  0, 32'h0,        5'h02, 32'h80000000, 4'b0010);
      vecs[27] = mk(5'd5,  5'd7,  0, 32'h0,        5'h04, 32'hFFFFFFFC, 4'b1010);

      // Reset with a write and a HI/LO load pending: both must lose to reset.
      idle();
      reset = 1'b1;
      @(negedge clk);
      bus.D_Addr = 5'd5; bus.DY = 32'hDEADBEEF; bus.Y_Sel = 3'd1; bus.D_En = 1'b1;
      bus.FS = 5'h18; bus.HILO_ld = 1'b1;
      do_clk();
      reset = 1'b0;
      idle();
      @(negedge clk);
      read_check("rst_r5", 5'd5, 32'd0);
      read_check("rst_r31", 5'd31, 32'd0);
      wb_reg(5'd20, 3'd3);
      read_check("rst_lo", 5'd20, 32'd0);
      wb_reg(5'd21, 3'd4);
      read_check("rst_hi", 5'd21, 32'd0);

      write_reg(5'd2,  32'h80000000);
      write_reg(5'd3,  32'h0F0F0000);
      write_reg(5'd4,  32'h000000F0);
      write_reg(5'd5,  32'h00000001);
      write_reg(5'd6,  32'd17);
      write_reg(5'd7,  32'd5);
      write_reg(5'd8,  32'd3);
      write_reg(5'd9,  32'hFFFFFFFF);
      write_reg(5'd10, 32'h7FFFFFFF);
      write_reg(5'd11, 32'hFFFFFFF9);

      for (int i = 0; i < NV; i++) begin
         idle();
         bus.S_Addr = vecs[i].s_addr; bus.T_Addr = vecs[i].t_addr;
         bus.T_Sel = vecs[i].t_sel; bus.DT = vecs[i].dt; bus.FS = vecs[i].fs;
         #1;
         check($sformatf("vec%0d", i), {bus.ALU_OUT, bus.C, bus.V, bus.N, bus.Z},
               {vecs[i].exp_y, vecs[i].exp_cvnz});
         @(negedge clk);
      end

      // OR into r1 through the ALU writeback path.
      idle();
      bus.S_Addr = 5'd3; bus.T_Addr = 5'd4; bus.FS = 5'h09;
      bus.D_Addr = 5'd1; bus.Y_Sel = 3'd2; bus.D_En = 1'b1;
      #1;
      check("or_z", {35'd0, bus.Z}, 36'd0);
      do_clk();
      read_check("or_r1", 5'd1, 32'h0F0F00F0);

      // Signed multiply 3 * -5 into HI/LO.
      load_hilo(5'd8, 5'd0, 1'b1, 32'hFFFFFFFB, 5'h1E);
      wb_reg(5'd14, 3'd4);
      wb_reg(5'd15, 3'd3);
      read_check("mul_hi", 5'd14, 32'hFFFFFFFF);
      read_check("mul_lo", 5'd15, 32'hFFFFFFF1);

      // 17 / 5, then a non-loading cycle must leave HI/LO alone.
      load_hilo(5'd6, 5'd7, 1'b0, 32'd0, 5'h1F);
      idle();
      bus.FS = 5'h18;
      do_clk();
      wb_reg(5'd16, 3'd3);
      wb_reg(5'd17, 3'd4);
      read_check("div_lo", 5'd16, 32'd3);
      read_check("div_hi", 5'd17, 32'd2);

      // -7 / 2: quotient -3, remainder -1.
      load_hilo(5'd11, 5'd0, 1'b1, 32'd2, 5'h1F);
      wb_reg(5'd18, 3'd4);
      read_check("divn_hi", 5'd18, 32'hFFFFFFFF);

      // Divide by zero: HI takes S.
      load_hilo(5'd6, 5'd0, 1'b0, 32'd0, 5'h1F);
      wb_reg(5'd19, 3'd4);
      read_check("div0_hi", 5'd19, 32'd17);

      write_reg(5'd0, 32'hABCDEF01);
      read_check("r0_wr", 5'd0, 32'd0);
      write_reg(5'd12, 32'hABCDEF01);
      read_check("r12_wr", 5'd12, 32'hABCDEF01);

      // Read r12 in the same cycle it is rewritten.
      idle();
      bus.S_Addr = 5'd12; bus.T_Addr = 5'd12; bus.FS = 5'h00;
      bus.D_Addr = 5'd12; bus.DY = 32'h55AA55AA; bus.Y_Sel = 3'd1; bus.D_En = 1'b1;
      #1;
`ifdef INTDP_WR_BYPASS_EN
      check("rdw_s", {4'd0, bus.ALU_OUT}, {4'd0, 32'h55AA55AA});
      check("rdw_t", {4'd0, bus.D_OUT}, {4'd0, 32'h55AA55AA});
`else
      check("rdw_s", {4'd0, bus.ALU_OUT}, {4'd0, 32'hABCDEF01});
      check("rdw_t", {4'd0, bus.D_OUT}, {4'd0, 32'hABCDEF01});
`endif
      do_clk();
      read_check("rdw_after", 5'd12, 32'h55AA55AA);

      idle();
      bus.PC_in = 32'h100100C0; bus.D_Addr = 5'd13; bus.Y_Sel = 3'd0; bus.D_En = 1'b1;
      do_clk();
      read_check("pc_r13", 5'd13, 32'h100100C0);

      idle();
      bus.DY = 32'h12345678; bus.PC_in = 32'h12345678;
      bus.D_Addr = 5'd12; bus.Y_Sel = 3'd5; bus.D_En = 1'b1;
      do_clk();
      read_check("ysel5", 5'd12, 32'd0);

      idle();
      reset = 1'b1;
      do_clk();
      reset = 1'b0;
      read_check("rst2_r13", 5'd13, 32'd0);
      read_check("rst2_r3", 5'd3, 32'd0);
      wb_reg(5'd20, 3'd4);
      read_check("rst2_hi", 5'd20, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/integer_datapath.md
INTEGER_DATAPATH -- requirements
Module: integer_datapath

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: S_Addr  in  5  register-file read address, S operand.
REQ-004 SHALL: T_Addr  in  5  register-file read address, T operand.
REQ-005 SHALL: D_Addr  in  5  register-file write address.
REQ-006 SHALL: D_En  in  1  register-file write enable.
REQ-007 SHALL: DT  in  32  external T operand (immediate).
REQ-008 SHALL: T_Sel  in  1  ALU T source: 0 = register T, 1 = DT.
REQ-009 SHALL: FS  in  5  ALU function select.
REQ-010 SHALL: HILO_ld  in  1  load HI/LO from ALU 64-bit result.
REQ-011 SHALL: DY  in  32  external writeback data (memory path).
REQ-012 SHALL: PC_in  in  32  external writeback data (PC path).
REQ-013 SHALL: Y_Sel  in  3  writeback select.
REQ-014 SHALL: C, V, N, Z  out  1 each  ALU carry, overflow, negative, zero flags.
REQ-015 SHALL: ALU_OUT  out  32  combinational ALU low result (Y_lo).
REQ-016 SHALL: D_OUT  out  32  register T read data (store data).

Function
REQ-017 SHALL: 32x32 register file, two combinational read ports, one write port; register 0 reads 0, writes to it ignored.
REQ-018 SHALL: write on rising clk when D_En=1, D_Addr≠0; data = writeback mux.
REQ-019 SHALL: writeback mux Y_Sel: 0 PC_in, 1 DY, 2 ALU_OUT, 3 LO, 4 HI, 5-7 zero.
REQ-020 SHALL: FS codes: 00 pass S; 01 pass T; 02 add unsigned; 03 add signed; 04 sub signed (S-T); 05 sub unsigned; 06 slt signed; 07 sltu; 08 and; 09 or; 0A xor; 0B nor; 0C srl T by 1; 0D sra T by 1; 0E sll T by 1; 13 inc S; 15 dec S; 17 zeros; 18 ones; 1E mul signed; 1F div signed; others output 0.
REQ-021 SHALL: mul: {Y_hi,Y_lo} = signed 64-bit S*T.
REQ-022 SHALL: div: Y_lo = signed S/T quotient (truncated toward zero), Y_hi = remainder with sign of S; T=0 gives Y_lo=FFFFFFFF, Y_hi=S.
REQ-023 SHALL: HI<=Y_hi, LO<=Y_lo on rising clk when HILO_ld=1; otherwise hold.
REQ-024 SHALL: Y_hi = 0 for non-mul/div functions.
REQ-025 SHALL: N = Y_lo[31]; Z = (Y_lo==0), for mul/div Z = ({Y_hi,Y_lo}==0).
REQ-026 SHALL: C = carry-out (add) or borrow (sub); V = two's-complement overflow for signed add/sub only; shifts set C to shifted-out bit; other functions C=V=0.
REQ-027 SHALL: all ALU, flag and mux paths purely combinational; single-cycle latency to register write.
REQ-028 SHALL: simultaneous read and write of same register returns old value (no bypass) unless REQ-032 enabled.

Reset
REQ-029 SHALL: on reset=1 at rising clk, all 32 registers, HI and LO clear to 0.
REQ-030 SHALL: reset overrides D_En and HILO_ld in the same cycle.

Configuration
REQ-031 SHALL: macro INTDP_WR_BYPASS_EN selects read-during-write behaviour.
REQ-032 SHALL: defined: read port whose address equals active D_Addr (≠0, D_En=1) returns writeback data; undefined: REQ-028 applies.

Verification
REQ-033 SHALL: r3=0F0F0000, r4=000000F0, FS=09, D_Addr=1, Y_Sel=2 -> r1=0F0F00F0, Z=0.
REQ-034 SHALL: S=80000000, T=00000001, FS=04 -> ALU_OUT=7FFFFFFF, V=1.
REQ-035 SHALL: S=3, T_Sel=1, DT=FFFFFFFB, FS=1E, HILO_ld=1, then Y_Sel=4/3 writes -> HI=FFFFFFFF, LO=FFFFFFF1.
REQ-036 SHALL: S=17, T=5, FS=1F, HILO_ld=1 -> LO=3, HI=2.
REQ-037 SHALL: D_En=1, D_Addr=0, Y_Sel=1, DY=ABCDEF01 -> r0 still reads 0; D_Addr=12 -> r12=ABCDEF01.
REQ-038 SHALL: Y_Sel=0, PC_in=100100C0, D_Addr=13 -> r13=100100C0; reset then reads 0.
